// File: rtl/solver_start_ctrl.sv
// Synchronises and debounces the board start request and holds a sticky start level until software acks.
// Optional ack timeout in ARMED is enabled by defining SOLVER_START_TIMEOUT_EN.
module solver_start_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       start_ack,
  output logic       start_out,
  output logic       busy,
  output logic [7:0] press_count,
  output logic       timeout_flag
);

  localparam int unsigned      CNT_LIMIT = 1 << CNT_W;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guards on the counter sizing.
  if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES >= CNT_LIMIT) begin : g_bad_debounce
    $error("solver_start_ctrl: DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES >= CNT_LIMIT) begin : g_bad_timeout
    $error("solver_start_ctrl: TIMEOUT_CYCLES out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ARMED,
    S_RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_q1;
  logic             btn_s;

`ifdef SOLVER_START_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_q;
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_q1 <= start_btn;
      btn_s   <= sync_q1;
    end
  end

  // Control FSM; outputs are registered alongside the state they reflect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      start_out   <= 1'b0;
      busy        <= 1'b0;
      press_count <= '0;
`ifdef SOLVER_START_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (btn_s) begin
            state <= S_DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (!btn_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state     <= S_ARMED;
            start_out <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ARMED: begin
          if (start_ack) begin
            state       <= S_RELEASE;
            start_out   <= 1'b0;
            cnt         <= '0;
            press_count <= press_count + 8'd1;
`ifdef SOLVER_START_TIMEOUT_EN
            timeout_q   <= 1'b0;
          end else if (cnt == TO_LAST) begin
            state     <= S_RELEASE;
            start_out <= 1'b0;
            cnt       <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
`endif
          end
        end
        S_RELEASE: begin
          // Any high sample restarts the release run.
          if (btn_s) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          start_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solver_start_ctrl.sv
// Self-checking bench for solver_start_ctrl: directed scenarios plus random button/ack traffic
// compared against a run-length reference model.
module tb_solver_start_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 20;
`ifdef SOLVER_START_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       start_ack;
  logic       start_out;
  logic       busy;
  logic [7:0] press_count;
  logic       timeout_flag;

  int total = 0;
  int bad   = 0;

  // Reference model: button delay line plus run lengths of the synchronised level.
  bit m_s1, m_s2;
  bit m_armed, m_release, m_tflag;
  int m_hi_run, m_lo_run, m_age, m_count;

  always #5 clk = ~clk;

  solver_start_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_btn   (start_btn),
    .start_ack   (start_ack),
    .start_out   (start_out),
    .busy        (busy),
    .press_count (press_count),
    .timeout_flag(timeout_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0;
    m_armed = 0; m_release = 0; m_tflag = 0;
    m_hi_run = 0; m_lo_run = 0; m_age = 0; m_count = 0;
  endtask

  task automatic model_edge(input bit b, input bit a);
    bit bs;
    bs = m_s2;
    if (m_armed) begin
      m_age++;
      if (a) begin
        m_armed = 0; m_release = 1; m_lo_run = 0;
        m_count = (m_count + 1) % 256;
        m_tflag = 0;
      end else if (TO_EN && m_age == int'(TO)) begin
        m_armed = 0; m_release = 1; m_lo_run = 0;
        m_tflag = 1;
      end
    end else if (m_release) begin
      if (bs) m_lo_run = 0;
      else begin
        m_lo_run++;
        if (m_lo_run == int'(DB)) begin
          m_release = 0; m_hi_run = 0;
        end
      end
    end else begin
      // From idle the entry sample plus DB further high samples are needed.
      if (bs) begin
        m_hi_run++;
        if (m_hi_run == int'(DB) + 1) begin
          m_armed = 1; m_age = 0; m_hi_run = 0;
        end
      end else m_hi_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/start_out"}, 32'(start_out), 32'(m_armed));
    chk({tag, "/busy"}, 32'(busy), 32'(m_armed | m_release | (m_hi_run > 0)));
    chk({tag, "/press_count"}, 32'(press_count), 32'(m_count));
    chk({tag, "/timeout_flag"}, 32'(timeout_flag), 32'(m_tflag));
  endtask

  task automatic tick(input bit b, input bit a, input string tag);
    start_btn = b;
    start_ack = a;
    @(posedge clk);
    model_edge(b, a);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    start_btn = 1'b0;
    start_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic wait_armed(input bit a, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (start_out) break;
      tick(1'b1, a, tag);
    end
    chk({tag, "/armed_reached"}, 32'(start_out), 32'd1);
  endtask

  initial begin
    int rises, hi_cycles, run;
    bit b, prev;
    start_btn = 1'b0;
    start_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/start_out", 32'(start_out), 32'd0);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/press_count", 32'(press_count), 32'd0);
    chk("reset/timeout_flag", 32'(timeout_flag), 32'd0);
    model_reset();
    reset = 1'b0;

    // Idle with no request.
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, "idle");
    chk("idle/busy_const", 32'(busy), 32'd0);

    // Clean press: start_out rises after the 7th sampled-high edge (2 sync + DB + 1).
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, "press");
    chk("press/not_yet", 32'(start_out), 32'd0);
    tick(1'b1, 1'b0, "press");
    chk("press/latency", 32'(start_out), 32'd1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, "armed_hold");
    tick(1'b1, 1'b1, "ack");
    chk("ack/start_out_low", 32'(start_out), 32'd0);
    chk("ack/press_count", 32'(press_count), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, "release");
    chk("release/still_busy", 32'(busy), 32'd1);
    tick(1'b0, 1'b0, "release");
    chk("release/busy_low", 32'(busy), 32'd0);

    // Bounce never arms.
    do_reset();
    rises = 0;
    tick(1'b1, 1'b0, "bounce"); tick(1'b1, 1'b0, "bounce");
    tick(1'b0, 1'b0, "bounce");
    tick(1'b1, 1'b0, "bounce"); tick(1'b1, 1'b0, "bounce");
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, "bounce");
      if (start_out) rises++;
    end
    chk("bounce/no_arm", 32'(rises), 32'd0);
    chk("bounce/busy", 32'(busy), 32'd0);
    chk("bounce/press_count", 32'(press_count), 32'd0);

    // Held button through ack: a single episode, ack ignored outside ARMED.
    do_reset();
    wait_armed(1'b0, "held");
    rises = 1;
    prev = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 1'b1, "held");
      if (start_out && !prev) rises++;
      prev = start_out;
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "short_release");
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, "short_release");
      if (start_out && !prev) rises++;
      prev = start_out;
    end
    chk("held/episodes", 32'(rises), 32'd1);
    chk("held/press_count", 32'(press_count), 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "held_release");
    chk("held/idle", 32'(busy), 32'd0);

    // Unacknowledged press.
    do_reset();
    wait_armed(1'b0, "noack");
    hi_cycles = 1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, "noack");
      if (!start_out) break;
      hi_cycles++;
    end
    if (TO_EN) begin
      chk("timeout/high_cycles", 32'(hi_cycles), 32'(TO));
      chk("timeout/flag", 32'(timeout_flag), 32'd1);
      chk("timeout/press_count", 32'(press_count), 32'd0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "timeout_release");
      wait_armed(1'b0, "timeout_repress");
      tick(1'b1, 1'b1, "timeout_ack");
      chk("timeout/flag_cleared", 32'(timeout_flag), 32'd0);
      chk("timeout/press_count_after", 32'(press_count), 32'd1);
    end else begin
      chk("noack/held_armed", 32'(hi_cycles), 32'd31);
      chk("noack/flag", 32'(timeout_flag), 32'd0);
      tick(1'b0, 1'b1, "noack_ack");
      chk("noack/press_count", 32'(press_count), 32'd1);
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "settle");

    // Reset in the middle of ARMED clears outputs without a clock edge.
    do_reset();
    wait_armed(1'b0, "midreset");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, "midreset");
    chk("midreset/armed_before", 32'(start_out), 32'd1);
    reset = 1'b1;
    #2;
    chk("midreset/start_out_async", 32'(start_out), 32'd0);
    chk("midreset/busy_async", 32'(busy), 32'd0);
    chk("midreset/press_count", 32'(press_count), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    wait_armed(1'b0, "after_reset");
    chk("after_reset/count_pre_ack", 32'(press_count), 32'd0);
    tick(1'b1, 1'b1, "after_reset_ack");
    chk("after_reset/count_post_ack", 32'(press_count), 32'd1);

    // Random button runs and acks against the model.
    do_reset();
    b = 1'b0;
    for (int n = 0; n < 250; n++) begin
      run = int'($urandom_range(1, 9));
      b = ~b;
      for (int i = 0; i < run; i++)
        tick(b, ($urandom_range(0, 3) == 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/solver_start_ctrl.md
# solver_start_ctrl

Conditions the raw board "start" request for the solver system and drives the single-bit input port of the solver start PIO that the Nios II polls. The block synchronises and debounces the asynchronous request, then holds a clean sticky start level until software acknowledges it through an output PIO bit. It also waits for a debounced release before re-arming and counts accepted starts. It sits between the board pin and the start PIO, in the same clock domain as the Avalon fabric.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required for press and for release; legal range 1 to 2^CNT_W−1.
- CNT_W, 20: width of the debounce and timeout counter.
- TIMEOUT_CYCLES, 1000000: ARMED cycles allowed before a timeout; used only with the timeout macro; must be below 2^CNT_W.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start_btn  input  1  raw start request, active-high, asynchronous to clk, may bounce.
- start_ack  input  1  software acknowledge level from an output PIO bit; synchronous to clk.
- start_out  output  1  clean sticky start level; connects to the start PIO in_port.
- busy  output  1  high in every state except IDLE.
- press_count  output  8  number of acknowledged starts; wraps 255→0.
- timeout_flag  output  1  sticky ack-timeout indicator.

## Operation
- start_btn passes through a 2-flop synchroniser to give btn_s. No other input is synchronised.
- State machine states and transitions:
  - IDLE: counter held at 0. btn_s=1 → DEBOUNCE.
  - DEBOUNCE: counter increments each cycle while btn_s=1. btn_s=0 → IDLE with counter cleared. btn_s=1 with counter==DEBOUNCE_CYCLES−1 → ARMED.
  - ARMED: start_out=1. start_ack=1 → RELEASE and press_count+1.
  - RELEASE: counter counts consecutive cycles with btn_s=0. Any btn_s=1 clears the counter. Counter==DEBOUNCE_CYCLES−1 with btn_s=0 → IDLE.
- start_out is registered and equals (state==ARMED). busy is registered and equals (state!=IDLE).
- start_ack is ignored outside ARMED. If ack is already high on entry to ARMED, start_out is high for exactly 1 cycle.
- A continuously held button produces exactly one ARMED episode per press.
- Counter increments saturate logically through the compare; the counter never wraps because the limits are below 2^CNT_W.

## Timing
- Reset values: all outputs 0, state IDLE, synchroniser flops 0, counter 0.
- Assert reset at any point, including mid-ARMED: outputs clear asynchronously and nothing is counted.
- Press latency: start_btn sampled high at edge N with no bounce → start_out high after edge N+1+DEBOUNCE_CYCLES+1 (2 sync stages plus DEBOUNCE_CYCLES debounce cycles).
- Ack latency: start_ack high at edge M in ARMED → start_out low and press_count updated after edge M. Software sees the level drop on its next PIO read.
- Release: re-arm is possible only after DEBOUNCE_CYCLES consecutive low btn_s samples in RELEASE.
- A single-cycle glitch on start_btn shorter than DEBOUNCE_CYCLES never reaches ARMED.

## Configuration
- SOLVER_START_TIMEOUT_EN defined:
  - ARMED reuses the counter, cleared on entry, to count cycles without ack.
  - Count reaching TIMEOUT_CYCLES−1 without ack → RELEASE, timeout_flag←1, press_count unchanged.
  - An ack and the timeout on the same edge: the ack wins.
  - timeout_flag is sticky; it clears only on reset or on the next accepted ack.
- SOLVER_START_TIMEOUT_EN undefined: ARMED waits indefinitely; timeout_flag is constant 0; TIMEOUT_CYCLES is unused.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8.
- Reset then idle 20 cycles → start_out=0, busy=0, press_count=0, timeout_flag=0.
- start_btn high steady from edge 10 → start_out rises after edge 16. Ack pulsed at edge 25 → start_out low after edge 25, press_count=1. Release held low → busy low 6 cycles later.
- start_btn bounce (high 2, low 1, high 2, low) → start_out never rises, busy returns to 0, press_count=0.
- Button held high through ack for 50 cycles, then released → exactly one start_out episode, press_count=1. No re-arm until 4 low samples.
- With SOLVER_START_TIMEOUT_EN, press with no ack → start_out high exactly 8 cycles, timeout_flag=1, press_count=0. Next acked press → timeout_flag=0, press_count=1.
- reset asserted 3 cycles into ARMED → start_out and busy drop asynchronously. After deassert the next press behaves normally and press_count=0 before its ack.
